// File: rtl/mem_stage_lsu_pkg.sv
// Shared types for the MEM-stage load/store unit: memory op codes, exception codes
// and op classification helpers.
package mem_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LW   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LHU  = 4'd3,
        MEM_LB   = 4'd4,
        MEM_LBU  = 4'd5,
        MEM_SW   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SB   = 4'd8
    } mem_op_t;

    typedef enum logic [1:0] {
        EXC_NONE = 2'd0,
        EXC_ADEL = 2'd1,
        EXC_ADES = 2'd2
    } exc_t;

    function automatic logic is_load(input mem_op_t op);
        case (op)
            MEM_LW, MEM_LH, MEM_LHU, MEM_LB, MEM_LBU: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input mem_op_t op);
        case (op)
            MEM_SW, MEM_SH, MEM_SB: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Word-wide data memory bus between the LSU (master) and the data memory (slave).
interface mem_stage_lsu_if;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic        dm_we;
    logic [31:0] dm_pc;
    logic [31:0] dm_rd;

    modport master (output dm_addr, output dm_wd, output dm_we, output dm_pc, input dm_rd);
    modport slave  (input dm_addr, input dm_wd, input dm_we, input dm_pc, output dm_rd);
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Combinational byte-lane logic: sub-word store merge, load extract/extend and
// alignment / range checking against the word-only data memory.
module mem_align
    import mem_pkg::*;
#(
    parameter int unsigned DM_BYTES = 32'd16384
) (
    input  mem_op_t     op,
    input  logic [31:0] addr,
    input  logic [31:0] rt,
    input  logic [31:0] rd,
    output logic [31:0] wd,
    output logic [31:0] ld_data,
    output exc_t        exc
);

    logic [1:0]  off_s;
    logic [4:0]  sh_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        misal_s;
    logic        oor_s;

    // Lane selection, store merge, load extension and exception classification
    always_comb begin
        off_s   = addr[1:0];
        sh_s    = {off_s, 3'b000};
        byte_s  = rd[sh_s +: 8];
        half_s  = off_s[1] ? rd[31:16] : rd[15:0];

        wd = rd;
        case (op)
            MEM_SW: wd = rt;
            MEM_SH: begin
                if (off_s[1]) begin
                    wd[31:16] = rt[15:0];
                end else begin
                    wd[15:0] = rt[15:0];
                end
            end
            MEM_SB:  wd[sh_s +: 8] = rt[7:0];
            default: wd = rd;
        endcase

        case (op)
            MEM_LW:  ld_data = rd;
            MEM_LH:  ld_data = {{16{half_s[15]}}, half_s};
            MEM_LHU: ld_data = {16'h0000, half_s};
            MEM_LB:  ld_data = {{24{byte_s[7]}}, byte_s};
            MEM_LBU: ld_data = {24'h000000, byte_s};
            default: ld_data = addr;
        endcase

        case (op)
            MEM_LW, MEM_SW:          misal_s = (off_s != 2'b00);
            MEM_LH, MEM_LHU, MEM_SH: misal_s = off_s[0];
            default:                 misal_s = 1'b0;
        endcase
        oor_s = (addr >= DM_BYTES);

        if (is_load(op) && (misal_s || oor_s)) begin
            exc = EXC_ADEL;
        end else if (is_store(op) && (misal_s || oor_s)) begin
            exc = EXC_ADES;
        end else begin
            exc = EXC_NONE;
        end
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage LSU: EX/MEM and MEM/WB pipeline registers, single-shot store write
// enable, and forwarding / load-use information for the hazard unit.
module mem_stage_lsu
    import mem_pkg::*;
#(
    parameter int unsigned DM_BYTES = 32'd16384,
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            hold,
    input  logic            flush,
    input  logic            ex_valid,
    input  logic [31:0]     ex_pc,
    input  logic [31:0]     ex_addr,
    input  logic [31:0]     ex_rt_data,
    input  mem_op_t         ex_mem_op,
    input  logic [4:0]      ex_rd_addr,
    input  logic            ex_reg_we,
    mem_stage_lsu_if.master dm,
    output logic            mem_fwd_valid,
    output logic [4:0]      mem_fwd_addr,
    output logic [31:0]     mem_fwd_data,
    output logic            mem_is_load,
    output logic            wb_valid,
    output logic [31:0]     wb_pc,
    output logic [4:0]      wb_rd_addr,
    output logic            wb_reg_we,
    output logic [31:0]     wb_wdata,
    output exc_t            wb_exc
);

    logic        em_valid_q,  em_valid_d;
    logic [31:0] em_pc_q,     em_pc_d;
    logic [31:0] em_addr_q,   em_addr_d;
    logic [31:0] em_rt_q,     em_rt_d;
    mem_op_t     em_op_q,     em_op_d;
    logic [4:0]  em_rd_q,     em_rd_d;
    logic        em_reg_we_q, em_reg_we_d;
    logic        store_done_q, store_done_d;

    logic        wb_valid_q,  wb_valid_d;
    logic [31:0] wb_pc_q,     wb_pc_d;
    logic [4:0]  wb_rd_q,     wb_rd_d;
    logic        wb_reg_we_q, wb_reg_we_d;
    logic [31:0] wb_wdata_q,  wb_wdata_d;
    exc_t        wb_exc_q,    wb_exc_d;

    logic [31:0] wd_s;
    logic [31:0] ld_data_s;
    exc_t        exc_s;
    logic        dm_we_s;

    mem_align #(.DM_BYTES(DM_BYTES)) u_align (
        .op      (em_op_q),
        .addr    (em_addr_q),
        .rt      (em_rt_q),
        .rd      (dm.dm_rd),
        .wd      (wd_s),
        .ld_data (ld_data_s),
        .exc     (exc_s)
    );

    // A store held in MEM writes once; store_done masks the repeats until EX/MEM advances
    always_comb begin
        dm_we_s = em_valid_q & is_store(em_op_q) & (exc_s == EXC_NONE) & ~store_done_q & ~reset;

        em_valid_d  = em_valid_q;
        em_pc_d     = em_pc_q;
        em_addr_d   = em_addr_q;
        em_rt_d     = em_rt_q;
        em_op_d     = em_op_q;
        em_rd_d     = em_rd_q;
        em_reg_we_d = em_reg_we_q;
        if (hold) begin
            store_done_d = store_done_q | dm_we_s;
        end else begin
            store_done_d = 1'b0;
            em_pc_d      = ex_pc;
            em_addr_d    = ex_addr;
            em_rt_d      = ex_rt_data;
            em_rd_d      = ex_rd_addr;
            if (flush) begin
                em_valid_d  = 1'b0;
                em_op_d     = MEM_NONE;
                em_reg_we_d = 1'b0;
            end else begin
                em_valid_d  = ex_valid;
                em_op_d     = ex_mem_op;
                em_reg_we_d = ex_reg_we;
            end
        end

        wb_valid_d  = wb_valid_q;
        wb_pc_d     = wb_pc_q;
        wb_rd_d     = wb_rd_q;
        wb_reg_we_d = wb_reg_we_q;
        wb_wdata_d  = wb_wdata_q;
        wb_exc_d    = wb_exc_q;
        if (!hold) begin
            wb_valid_d  = em_valid_q;
            wb_pc_d     = em_pc_q;
            wb_rd_d     = em_rd_q;
            wb_reg_we_d = em_valid_q & em_reg_we_q & (exc_s == EXC_NONE);
            wb_wdata_d  = ld_data_s;
            wb_exc_d    = em_valid_q ? exc_s : EXC_NONE;
        end else begin
            wb_valid_d  = wb_valid_q;
        end
    end

    // Pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            em_valid_q   <= 1'b0;
            em_pc_q      <= PC_RESET;
            em_addr_q    <= 32'h0000_0000;
            em_rt_q      <= 32'h0000_0000;
            em_op_q      <= MEM_NONE;
            em_rd_q      <= 5'd0;
            em_reg_we_q  <= 1'b0;
            store_done_q <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_pc_q      <= PC_RESET;
            wb_rd_q      <= 5'd0;
            wb_reg_we_q  <= 1'b0;
            wb_wdata_q   <= 32'h0000_0000;
            wb_exc_q     <= EXC_NONE;
        end else begin
            em_valid_q   <= em_valid_d;
            em_pc_q      <= em_pc_d;
            em_addr_q    <= em_addr_d;
            em_rt_q      <= em_rt_d;
            em_op_q      <= em_op_d;
            em_rd_q      <= em_rd_d;
            em_reg_we_q  <= em_reg_we_d;
            store_done_q <= store_done_d;
            wb_valid_q   <= wb_valid_d;
            wb_pc_q      <= wb_pc_d;
            wb_rd_q      <= wb_rd_d;
            wb_reg_we_q  <= wb_reg_we_d;
            wb_wdata_q   <= wb_wdata_d;
            wb_exc_q     <= wb_exc_d;
        end
    end

    assign dm.dm_addr = {em_addr_q[31:2], 2'b00};
    assign dm.dm_wd   = wd_s;
    assign dm.dm_we   = dm_we_s;
    assign dm.dm_pc   = em_pc_q;

    assign mem_fwd_valid = em_valid_q & em_reg_we_q & ~is_load(em_op_q) & (em_rd_q != 5'd0);
    assign mem_fwd_addr  = em_rd_q;
    assign mem_fwd_data  = em_addr_q;
    assign mem_is_load   = em_valid_q & is_load(em_op_q);

    assign wb_valid   = wb_valid_q;
    assign wb_pc      = wb_pc_q;
    assign wb_rd_addr = wb_rd_q;
    assign wb_reg_we  = wb_reg_we_q;
    assign wb_wdata   = wb_wdata_q;
    assign wb_exc     = wb_exc_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: stores, loads, exceptions, hold, flush, reset.
module tb_mem_stage_lsu;
    import mem_pkg::*;

    logic        clk;
    logic        reset;
    logic        hold;
    logic        flush;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_addr;
    logic [31:0] ex_rt_data;
    mem_op_t     ex_mem_op;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_we;
    logic        mem_fwd_valid;
    logic [4:0]  mem_fwd_addr;
    logic [31:0] mem_fwd_data;
    logic        mem_is_load;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [4:0]  wb_rd_addr;
    logic        wb_reg_we;
    logic [31:0] wb_wdata;
    exc_t        wb_exc;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage_lsu_if dm_bus ();

    mem_stage_lsu dut (
        .clk           (clk),
        .reset         (reset),
        .hold          (hold),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_addr       (ex_addr),
        .ex_rt_data    (ex_rt_data),
        .ex_mem_op     (ex_mem_op),
        .ex_rd_addr    (ex_rd_addr),
        .ex_reg_we     (ex_reg_we),
        .dm            (dm_bus.master),
        .mem_fwd_valid (mem_fwd_valid),
        .mem_fwd_addr  (mem_fwd_addr),
        .mem_fwd_data  (mem_fwd_data),
        .mem_is_load   (mem_is_load),
        .wb_valid      (wb_valid),
        .wb_pc         (wb_pc),
        .wb_rd_addr    (wb_rd_addr),
        .wb_reg_we     (wb_reg_we),
        .wb_wdata      (wb_wdata),
        .wb_exc        (wb_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic drive_ex(input mem_op_t op, input logic [31:0] pc, input logic [31:0] addr,
                            input logic [31:0] rt, input logic [4:0] rd, input logic we);
        ex_valid   = 1'b1;
        ex_mem_op  = op;
        ex_pc      = pc;
        ex_addr    = addr;
        ex_rt_data = rt;
        ex_rd_addr = rd;
        ex_reg_we  = we;
    endtask

    task automatic bubble_ex();
        ex_valid  = 1'b0;
        ex_mem_op = MEM_NONE;
        ex_reg_we = 1'b0;
    endtask

    // Instruction enters MEM; returns #2 after the edge with EX driven with a bubble
    task automatic enter_mem();
        @(posedge clk);
        #1;
        bubble_ex();
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        hold  = 1'b0;
        flush = 1'b0;
        ex_pc = 32'h0; ex_addr = 32'h0; ex_rt_data = 32'h0; ex_rd_addr = 5'd0;
        bubble_ex();
        dm_bus.dm_rd = 32'h0000_0000;
        next_cycle();
        next_cycle();
        chk("reset_dm_we", 32'(dm_bus.dm_we), 32'd0);
        reset = 1'b0;
        #1;
        chk("reset_wb_valid", 32'(wb_valid), 32'd0);
        chk("reset_wb_pc", wb_pc, 32'h0000_3000);
        chk("reset_dm_pc", dm_bus.dm_pc, 32'h0000_3000);
        chk("reset_wb_exc", 32'(wb_exc), 32'd0);
        chk("reset_wb_wdata", wb_wdata, 32'h0);
        chk("reset_wb_reg_we", 32'(wb_reg_we), 32'd0);
        chk("reset_is_load", 32'(mem_is_load), 32'd0);

        // SW 0x10
        drive_ex(MEM_SW, 32'h0000_3004, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0, 1'b0);
        enter_mem();
        chk("sw_dm_we", 32'(dm_bus.dm_we), 32'd1);
        chk("sw_dm_addr", dm_bus.dm_addr, 32'h0000_0010);
        chk("sw_dm_wd", dm_bus.dm_wd, 32'hDEAD_BEEF);
        chk("sw_dm_pc", dm_bus.dm_pc, 32'h0000_3004);
        next_cycle();
        chk("sw_wb_valid", 32'(wb_valid), 32'd1);
        chk("sw_wb_exc", 32'(wb_exc), 32'd0);

        // LW 0x10
        dm_bus.dm_rd = 32'hDEAD_BEEF;
        drive_ex(MEM_LW, 32'h0000_3008, 32'h0000_0010, 32'h0, 5'd3, 1'b1);
        enter_mem();
        chk("lw_is_load", 32'(mem_is_load), 32'd1);
        chk("lw_fwd_valid", 32'(mem_fwd_valid), 32'd0);
        chk("lw_dm_we", 32'(dm_bus.dm_we), 32'd0);
        next_cycle();
        chk("lw_wdata", wb_wdata, 32'hDEAD_BEEF);
        chk("lw_reg_we", 32'(wb_reg_we), 32'd1);
        chk("lw_rd", 32'(wb_rd_addr), 32'd3);
        chk("lw_pc", wb_pc, 32'h0000_3008);

        // SB 0x11
        dm_bus.dm_rd = 32'h1122_3344;
        drive_ex(MEM_SB, 32'h0000_300C, 32'h0000_0011, 32'h0000_00AA, 5'd0, 1'b0);
        enter_mem();
        chk("sb_dm_we", 32'(dm_bus.dm_we), 32'd1);
        chk("sb_dm_addr", dm_bus.dm_addr, 32'h0000_0010);
        chk("sb_dm_wd", dm_bus.dm_wd, 32'h1122_AA44);
        next_cycle();

        dm_bus.dm_rd = 32'h1122_AA44;
        drive_ex(MEM_LB, 32'h0000_3010, 32'h0000_0011, 32'h0, 5'd4, 1'b1);
        enter_mem();
        next_cycle();
        chk("lb_wdata", wb_wdata, 32'hFFFF_FFAA);
        drive_ex(MEM_LBU, 32'h0000_3014, 32'h0000_0011, 32'h0, 5'd4, 1'b1);
        enter_mem();
        next_cycle();
        chk("lbu_wdata", wb_wdata, 32'h0000_00AA);

        // SH 0x22
        dm_bus.dm_rd = 32'h1122_3344;
        drive_ex(MEM_SH, 32'h0000_3018, 32'h0000_0022, 32'h0000_8001, 5'd0, 1'b0);
        enter_mem();
        chk("sh_dm_we", 32'(dm_bus.dm_we), 32'd1);
        chk("sh_dm_addr", dm_bus.dm_addr, 32'h0000_0020);
        chk("sh_dm_wd", dm_bus.dm_wd, 32'h8001_3344);
        next_cycle();

        dm_bus.dm_rd = 32'h8001_3344;
        drive_ex(MEM_LH, 32'h0000_301C, 32'h0000_0022, 32'h0, 5'd6, 1'b1);
        enter_mem();
        next_cycle();
        chk("lh_wdata", wb_wdata, 32'hFFFF_8001);
        drive_ex(MEM_LHU, 32'h0000_3020, 32'h0000_0022, 32'h0, 5'd6, 1'b1);
        enter_mem();
        next_cycle();
        chk("lhu_wdata", wb_wdata, 32'h0000_8001);

        // Misaligned LW, misaligned SH, out-of-range SW
        drive_ex(MEM_LW, 32'h0000_3024, 32'h0000_0013, 32'h0, 5'd7, 1'b1);
        enter_mem();
        next_cycle();
        chk("lw_mis_exc", 32'(wb_exc), 32'(EXC_ADEL));
        chk("lw_mis_reg_we", 32'(wb_reg_we), 32'd0);
        chk("lw_mis_valid", 32'(wb_valid), 32'd1);

        drive_ex(MEM_SH, 32'h0000_3028, 32'h0000_0021, 32'h0000_1234, 5'd0, 1'b0);
        enter_mem();
        chk("sh_mis_dm_we", 32'(dm_bus.dm_we), 32'd0);
        next_cycle();
        chk("sh_mis_exc", 32'(wb_exc), 32'(EXC_ADES));

        drive_ex(MEM_SW, 32'h0000_302C, 32'h0000_4000, 32'h0000_5555, 5'd0, 1'b0);
        enter_mem();
        chk("sw_oor_dm_we", 32'(dm_bus.dm_we), 32'd0);
        next_cycle();
        chk("sw_oor_exc", 32'(wb_exc), 32'(EXC_ADES));

        // Forwardable ALU result, then rd=0 which must not forward
        drive_ex(MEM_NONE, 32'h0000_3030, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
        enter_mem();
        chk("alu_fwd_valid", 32'(mem_fwd_valid), 32'd1);
        chk("alu_fwd_addr", 32'(mem_fwd_addr), 32'd5);
        chk("alu_fwd_data", mem_fwd_data, 32'h0000_1234);
        chk("alu_is_load", 32'(mem_is_load), 32'd0);
        next_cycle();
        chk("alu_wdata", wb_wdata, 32'h0000_1234);
        chk("alu_reg_we", 32'(wb_reg_we), 32'd1);
        chk("alu_exc", 32'(wb_exc), 32'd0);
        drive_ex(MEM_NONE, 32'h0000_3034, 32'h0000_1234, 32'h0, 5'd0, 1'b1);
        enter_mem();
        chk("alu_r0_fwd_valid", 32'(mem_fwd_valid), 32'd0);
        next_cycle();

        // SW held three cycles in MEM: one write, MEM/WB frozen
        drive_ex(MEM_SW, 32'h0000_3040, 32'h0000_0030, 32'h0000_0055, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        bubble_ex();
        hold = 1'b1;
        #1;
        chk("hold_c1_dm_we", 32'(dm_bus.dm_we), 32'd1);
        next_cycle();
        chk("hold_c2_dm_we", 32'(dm_bus.dm_we), 32'd0);
        chk("hold_c2_wb_pc", wb_pc, 32'h0000_3034);
        next_cycle();
        chk("hold_c3_dm_we", 32'(dm_bus.dm_we), 32'd0);
        chk("hold_c3_wb_pc", wb_pc, 32'h0000_3034);
        hold = 1'b0;
        #1;
        chk("hold_rel_dm_we", 32'(dm_bus.dm_we), 32'd0);
        next_cycle();
        chk("hold_after_wb_pc", wb_pc, 32'h0000_3040);
        chk("hold_after_wb_valid", 32'(wb_valid), 32'd1);

        // Flush a valid store in EX
        drive_ex(MEM_SW, 32'h0000_3050, 32'h0000_0040, 32'h0000_0001, 5'd0, 1'b0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bubble_ex();
        #1;
        chk("flush_dm_we", 32'(dm_bus.dm_we), 32'd0);
        next_cycle();
        chk("flush_wb_valid", 32'(wb_valid), 32'd0);

        // Hold and flush together: hold keeps the load in MEM
        drive_ex(MEM_LW, 32'h0000_3060, 32'h0000_0050, 32'h0, 5'd8, 1'b1);
        @(posedge clk);
        #1;
        bubble_ex();
        hold  = 1'b1;
        flush = 1'b1;
        #1;
        chk("hf_is_load_c1", 32'(mem_is_load), 32'd1);
        next_cycle();
        chk("hf_is_load_c2", 32'(mem_is_load), 32'd1);
        hold  = 1'b0;
        flush = 1'b0;
        next_cycle();
        chk("hf_wb_pc", wb_pc, 32'h0000_3060);

        // Reset arriving while a store sits in MEM
        drive_ex(MEM_SW, 32'h0000_3070, 32'h0000_0060, 32'h0000_0077, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        bubble_ex();
        reset = 1'b1;
        #1;
        chk("rst_mid_dm_we", 32'(dm_bus.dm_we), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_mid_wb_pc", wb_pc, 32'h0000_3000);
        chk("rst_mid_wb_wdata", wb_wdata, 32'h0);
        chk("rst_mid_wb_rd", 32'(wb_rd_addr), 32'd0);
        chk("rst_mid_dm_we2", 32'(dm_bus.dm_we), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
